soundbar_mode_ctrl: RTL and testbench
=====================================

SOUNDBAR_MODE_CTRL -- requirements
Module: soundbar_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 500000, is the number of consecutive stable cycles needed to accept a button level change (5 ms at 100 MHz).
REQ-002 Parameter AUTO_PERIOD, default 50000000, is the number of cycles between auto-sweep steps (0.5 s at 100 MHz).
REQ-003 clock  input  1  is the single system clock; all state is on its rising edge.
REQ-004 resetn  input  1  is an asynchronous, active-low reset.
REQ-005 btnU, btnL, btnR, btnC  input  1 each  are raw, asynchronous pushbuttons, active-high.
REQ-006 auto_en  input  1  is a slide switch: 1 requests auto-sweep, 0 requests manual mode.
REQ-007 U  output  2  selects soundbar frame size; only values 0, 1 or 2 are legal.
REQ-008 L  output  2  selects soundbar position, 0 to 3.
REQ-009 R  output  2  selects soundbar colour scheme, 0 to 3.
REQ-010 mode_changed  output  1  is a one-cycle strobe, high in the first cycle any of U, L or R shows a new value.
REQ-011 state  output  2  reports the FSM state: MANUAL=0, AUTO=1, PAUSE=2.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-013 Debounce, per button:
- The counter increments while the synchronized level differs from the stable level.
- The counter clears to 0 when the two levels are equal.
- When the counter equals DEBOUNCE_CYC-1 and the levels still differ, the stable level takes the synchronized level and the counter clears.
REQ-014 The press pulse SHALL be high for exactly one cycle, when the stable level rises from 0 to 1; releases SHALL produce no pulse.
REQ-015 Output registers SHALL update on the clock edge after the press pulse, so a clean press changes outputs exactly DEBOUNCE_CYC+3 cycles after the raw rise.
REQ-016 A raw glitch shorter than DEBOUNCE_CYC cycles SHALL produce no pulse.
REQ-017 FSM transitions:
- auto_en=0 in any state: go to MANUAL on the next edge.
- MANUAL with auto_en=1: go to AUTO.
- AUTO with C pulse: go to PAUSE.
- PAUSE with C pulse: go to AUTO.
REQ-018 MANUAL:
- U pulse steps U 0→1→2→0.
- L pulse steps L 0→1→2→3→0.
- R pulse steps R 0→1→2→3→0.
- C pulse sets U, L and R to 0.
REQ-019 In MANUAL, C has priority: if C pulses in the same cycle as U, L or R, only the clear applies.
REQ-020 In MANUAL, simultaneous U, L and R pulses SHALL each apply in the same cycle.
REQ-021 AUTO:
- A timer counts 0 to AUTO_PERIOD-1, then wraps.
- On each wrap, L increments.
- When L wraps 3→0, U also advances 0→1→2→0.
- R pulses step R as in MANUAL; U and L pulses are ignored.
REQ-022 The AUTO timer SHALL clear to 0 on every entry to AUTO, including resume from PAUSE.
REQ-023 PAUSE: U and L are frozen and the timer holds its value; R pulses still step R.
REQ-024 U SHALL never take the value 3; if U reads 3 (unreachable), its next update SHALL set it to 0.
REQ-025 mode_changed SHALL be registered and high exactly when any of U, L or R differs from its previous-cycle value.
REQ-026 A C-clear that leaves all outputs unchanged SHALL NOT raise mode_changed.

Reset
REQ-027 While resetn=0, the following SHALL hold immediately, independent of clock:
- U=0, L=0, R=0, mode_changed=0, state=MANUAL.
- All synchronizers, stable levels, debounce counters and the timer are 0.
REQ-028 Reset asserted mid-debounce or mid-sweep SHALL discard the partial count; after release, a held button needs a full new DEBOUNCE_CYC qualification.
REQ-029 Operation SHALL resume on the first clock edge after resetn rises; no output changes in that cycle.

Verification (DEBOUNCE_CYC=4, AUTO_PERIOD=8)
REQ-030 Manual step: in MANUAL, btnU held high 10 cycles from cycle t → U goes 0→1 at t+7, mode_changed high only at t+7, no second step on release.
REQ-031 Glitch rejection: btnL high for 3 cycles → L stays 0 and mode_changed stays 0.
REQ-032 Wrap and priority: three U presses → U sequence 1, 2, 0; then btnC and btnR rise together with U=1, R=2 → U=0, L=0, R=0.
REQ-033 Auto sweep: auto_en=1 from reset → L steps every 8 cycles 1, 2, 3, 0; U becomes 1 on the 4th step; mode_changed pulses on each step.
REQ-034 Pause/resume: in AUTO, C press → state=2 and L frozen for 40 cycles; second C press → state=1 and the next L step occurs 8 cycles after re-entry; auto_en=0 → state=0 next cycle.
REQ-035 Async reset: resetn low mid-sweep between clock edges → all outputs 0 before the next edge; a btnU held across release steps U only DEBOUNCE_CYC+3 cycles after release.

Source files
------------

// File: rtl/soundbar_mode_ctrl_if.sv
// Button, switch and mode-output bundle for the soundbar mode controller.
// The master side drives the pushbuttons and the slide switch.
interface soundbar_mode_ctrl_if;
  logic       btnU;
  logic       btnL;
  logic       btnR;
  logic       btnC;
  logic       auto_en;
  logic [1:0] U;
  logic [1:0] L;
  logic [1:0] R;
  logic       mode_changed;
  logic [1:0] state;

  modport master (
    output btnU, btnL, btnR, btnC, auto_en,
    input  U, L, R, mode_changed, state
  );

  modport slave (
    input  btnU, btnL, btnR, btnC, auto_en,
    output U, L, R, mode_changed, state
  );
endinterface

// File: rtl/soundbar_mode_ctrl.sv
// Soundbar mode controller: debounced pushbuttons step frame size, position and
// colour manually, or an auto-sweep timer walks position/size with pause support.
module soundbar_mode_ctrl #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int AUTO_PERIOD  = 50000000
) (
  input logic clock,
  input logic resetn,
  soundbar_mode_ctrl_if.slave bus
);

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int TW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(AUTO_PERIOD - 1);

  localparam int BTN_U = 0;
  localparam int BTN_L = 1;
  localparam int BTN_R = 2;
  localparam int BTN_C = 3;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_AUTO   = 2'd1,
    ST_PAUSE  = 2'd2
  } state_t;

  logic [3:0]    raw_s;
  logic [3:0]    sync1_r;
  logic [3:0]    sync2_r;
  logic [3:0]    stable_r;
  logic [3:0]    press_r;
  logic [DW-1:0] cnt_r [4];

  state_t        st_r;
  state_t        st_nxt_s;
  logic [1:0]    u_r;
  logic [1:0]    l_r;
  logic [1:0]    r_r;
  logic [1:0]    u_nxt_s;
  logic [1:0]    l_nxt_s;
  logic [1:0]    r_nxt_s;
  logic [TW-1:0] tmr_r;
  logic [TW-1:0] tmr_nxt_s;
  logic          mc_r;

  // Frame size cycles through 0,1,2 only; any out-of-range value recovers to 0.
  function automatic logic [1:0] step_u(input logic [1:0] v);
    logic [1:0] res;
    if (v >= 2'd2) begin
      res = 2'd0;
    end else begin
      res = v + 2'd1;
    end
    return res;
  endfunction

  assign raw_s = {bus.btnC, bus.btnR, bus.btnL, bus.btnU};

  // Per-button synchronizer, debounce counter and rising-edge press pulse.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_r  <= 4'b0000;
      sync2_r  <= 4'b0000;
      stable_r <= 4'b0000;
      press_r  <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          cnt_r[i]   <= '0;
          press_r[i] <= 1'b0;
        end else if (cnt_r[i] == DEB_LAST) begin
          cnt_r[i]    <= '0;
          stable_r[i] <= sync2_r[i];
          press_r[i]  <= sync2_r[i];
        end else begin
          cnt_r[i]   <= cnt_r[i] + DW'(1);
          press_r[i] <= 1'b0;
        end
      end
    end
  end

  // Next-state and next-output decision for the mode FSM.
  always_comb begin
    st_nxt_s  = st_r;
    u_nxt_s   = u_r;
    l_nxt_s   = l_r;
    r_nxt_s   = r_r;
    tmr_nxt_s = tmr_r;
    case (st_r)
      ST_MANUAL: begin
        tmr_nxt_s = '0;
        if (press_r[BTN_C]) begin
          u_nxt_s = 2'd0;
          l_nxt_s = 2'd0;
          r_nxt_s = 2'd0;
        end else begin
          if (press_r[BTN_U]) begin
            u_nxt_s = step_u(u_r);
          end else begin
            u_nxt_s = u_r;
          end
          if (press_r[BTN_L]) begin
            l_nxt_s = l_r + 2'd1;
          end else begin
            l_nxt_s = l_r;
          end
          if (press_r[BTN_R]) begin
            r_nxt_s = r_r + 2'd1;
          end else begin
            r_nxt_s = r_r;
          end
        end
        if (bus.auto_en) begin
          st_nxt_s = ST_AUTO;
        end else begin
          st_nxt_s = ST_MANUAL;
        end
      end
      ST_AUTO: begin
        // Position advances on every timer wrap; frame size carries on position wrap.
        if (tmr_r >= TMR_LAST) begin
          tmr_nxt_s = '0;
          l_nxt_s   = l_r + 2'd1;
          if (l_r == 2'd3) begin
            u_nxt_s = step_u(u_r);
          end else begin
            u_nxt_s = u_r;
          end
        end else begin
          tmr_nxt_s = tmr_r + TW'(1);
        end
        if (press_r[BTN_R]) begin
          r_nxt_s = r_r + 2'd1;
        end else begin
          r_nxt_s = r_r;
        end
        if (!bus.auto_en) begin
          st_nxt_s = ST_MANUAL;
        end else if (press_r[BTN_C]) begin
          st_nxt_s = ST_PAUSE;
        end else begin
          st_nxt_s = ST_AUTO;
        end
      end
      ST_PAUSE: begin
        if (press_r[BTN_R]) begin
          r_nxt_s = r_r + 2'd1;
        end else begin
          r_nxt_s = r_r;
        end
        if (!bus.auto_en) begin
          st_nxt_s = ST_MANUAL;
        end else if (press_r[BTN_C]) begin
          st_nxt_s  = ST_AUTO;
          tmr_nxt_s = '0;
        end else begin
          st_nxt_s = ST_PAUSE;
        end
      end
      default: begin
        st_nxt_s  = ST_MANUAL;
        tmr_nxt_s = '0;
      end
    endcase
  end

  // Registered state, outputs, sweep timer and change strobe.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      st_r  <= ST_MANUAL;
      u_r   <= 2'd0;
      l_r   <= 2'd0;
      r_r   <= 2'd0;
      tmr_r <= '0;
      mc_r  <= 1'b0;
    end else begin
      st_r  <= st_nxt_s;
      u_r   <= u_nxt_s;
      l_r   <= l_nxt_s;
      r_r   <= r_nxt_s;
      tmr_r <= tmr_nxt_s;
      mc_r  <= (u_nxt_s != u_r) || (l_nxt_s != l_r) || (r_nxt_s != r_r);
    end
  end

  assign bus.U            = u_r;
  assign bus.L            = l_r;
  assign bus.R            = r_r;
  assign bus.mode_changed = mc_r;
  assign bus.state        = st_r;

endmodule

// File: tb/tb_soundbar_mode_ctrl.sv
// Bench for soundbar_mode_ctrl: directed scenarios plus randomized button traffic,
// all compared against a behavioural model of the debounce window and mode rules.
module tb_soundbar_mode_ctrl;
  localparam int DEB    = 4;
  localparam int AUTO_P = 8;

  logic clock = 1'b0;
  logic resetn;
  soundbar_mode_ctrl_if bus ();

  soundbar_mode_ctrl #(.DEBOUNCE_CYC(DEB), .AUTO_PERIOD(AUTO_P)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks;
  int passed;
  int cyc;

  // model state: outputs as plain integers, mode 0=manual 1=auto 2=pause
  int         m_u, m_l, m_r, m_mode, m_tmr;
  logic       m_mc;
  logic [3:0] m_stable;
  logic [3:0] m_press;
  logic [3:0] hist[$];

  logic [8:0] dut_vec;
  assign dut_vec = {bus.U, bus.L, bus.R, bus.mode_changed, bus.state};

  function automatic logic [8:0] model_vec();
    return {2'(m_u), 2'(m_l), 2'(m_r), m_mc, 2'(m_mode)};
  endfunction

  task automatic model_reset();
    m_u = 0; m_l = 0; m_r = 0; m_mode = 0; m_tmr = 0;
    m_mc = 1'b0;
    m_stable = 4'b0000;
    m_press  = 4'b0000;
    hist.delete();
    for (int i = 0; i < 8; i++) hist.push_back(4'b0000);
  endtask

  // One clock edge of the behavioural model; raw buttons reach the logic two edges late
  // and a level is accepted once DEB consecutive delayed samples disagree with it.
  task automatic model_step();
    int nu, nl, nr, nt, nm;
    logic [3:0] np;
    logic [3:0] s;
    logic all_diff;
    nu = m_u; nl = m_l; nr = m_r; nt = m_tmr; nm = m_mode;
    if (m_mode == 0) begin
      nt = 0;
      if (m_press[3]) begin
        nu = 0; nl = 0; nr = 0;
      end else begin
        if (m_press[0]) nu = (m_u + 1) % 3;
        if (m_press[1]) nl = (m_l + 1) % 4;
        if (m_press[2]) nr = (m_r + 1) % 4;
      end
      nm = bus.auto_en ? 1 : 0;
    end else if (m_mode == 1) begin
      if (m_tmr == AUTO_P - 1) begin
        nt = 0;
        nl = (m_l + 1) % 4;
        if (m_l == 3) nu = (m_u + 1) % 3;
      end else begin
        nt = m_tmr + 1;
      end
      if (m_press[2]) nr = (m_r + 1) % 4;
      nm = !bus.auto_en ? 0 : (m_press[3] ? 2 : 1);
    end else begin
      if (m_press[2]) nr = (m_r + 1) % 4;
      if (!bus.auto_en) nm = 0;
      else if (m_press[3]) begin nm = 1; nt = 0; end
    end
    m_mc = (nu != m_u) || (nl != m_l) || (nr != m_r);
    m_u = nu; m_l = nl; m_r = nr; m_tmr = nt; m_mode = nm;

    hist.push_front({bus.btnC, bus.btnR, bus.btnL, bus.btnU});
    if (hist.size() > 16) void'(hist.pop_back());
    np = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      for (int j = 2; j < DEB + 2; j++) begin
        s = hist[j];
        if (s[b] == m_stable[b]) all_diff = 1'b0;
      end
      if (all_diff) begin
        m_stable[b] = ~m_stable[b];
        np[b] = m_stable[b];
      end
    end
    m_press = np;
  endtask

  task automatic tick();
    @(posedge clock);
    if (resetn) model_step();
    else model_reset();
    @(negedge clock);
    cyc++;
  endtask

  task automatic set_btns(input logic [3:0] v);
    bus.btnU = v[0]; bus.btnL = v[1]; bus.btnR = v[2]; bus.btnC = v[3];
  endtask

  task automatic apply_reset(input logic ae);
    bus.auto_en = ae;
    set_btns(4'b0000);
    resetn = 1'b0;
    model_reset();
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic press_btn(input logic [3:0] mask);
    set_btns(mask);
    for (int n = 0; n < 7; n++) tick();
    set_btns(4'b0000);
    for (int n = 0; n < 7; n++) tick();
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    bus.auto_en = 1'b0;
    set_btns(4'b0000);
    #1 resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 9'd0) $display("FAIL reset_async got=%h exp=%h", dut_vec, 9'd0);
    else passed++;
    set_btns(4'b1111);
    for (int n = 0; n < 6; n++) begin
      tick();
      checks++;
      if (dut_vec !== 9'd0) $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, dut_vec, 9'd0);
      else passed++;
    end
    set_btns(4'b0000);
    resetn = 1'b1;
    tick();
    checks++;
    if (dut_vec !== model_vec() || dut_vec !== 9'd0)
      $display("FAIL reset_release got=%h exp=%h", dut_vec, model_vec());
    else passed++;
  endtask

  task automatic test_manual_step();
    apply_reset(1'b0);
    bus.btnU = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      if (n == 11) bus.btnU = 1'b0;
      tick();
      checks++;
      if (dut_vec !== model_vec()) $display("FAIL manual_model n=%0d got=%h exp=%h", n, dut_vec, model_vec());
      else passed++;
      checks++;
      if (bus.U !== ((n >= 7) ? 2'd1 : 2'd0) || bus.mode_changed !== (n == 7))
        $display("FAIL manual_step n=%0d got U=%0d mc=%b exp U=%0d mc=%b", n, bus.U, bus.mode_changed, (n >= 7) ? 1 : 0, (n == 7));
      else passed++;
    end
  endtask

  task automatic test_glitch();
    apply_reset(1'b0);
    for (int n = 1; n <= 20; n++) begin
      bus.btnL = (n <= 3);
      tick();
      checks++;
      if (dut_vec !== model_vec() || bus.L !== 2'd0 || bus.mode_changed !== 1'b0)
        $display("FAIL glitch_reject n=%0d got=%h exp=%h", n, dut_vec, model_vec());
      else passed++;
    end
    for (int n = 1; n <= 20; n++) begin
      bus.btnL = (n <= 4);
      tick();
      checks++;
      if (dut_vec !== model_vec() || bus.L !== ((n >= 7) ? 2'd1 : 2'd0))
        $display("FAIL glitch_boundary n=%0d got L=%0d exp L=%0d", n, bus.L, (n >= 7) ? 1 : 0);
      else passed++;
    end
  endtask

  task automatic test_wrap_priority();
    int exp_u[3] = '{1, 2, 0};
    apply_reset(1'b0);
    for (int p = 0; p < 3; p++) begin
      press_btn(4'b0001);
      checks++;
      if (bus.U !== 2'(exp_u[p]) || dut_vec !== model_vec())
        $display("FAIL u_wrap press=%0d got U=%0d exp U=%0d", p, bus.U, exp_u[p]);
      else passed++;
    end
    press_btn(4'b0001);
    press_btn(4'b0100);
    press_btn(4'b0100);
    checks++;
    if (bus.U !== 2'd1 || bus.R !== 2'd2 || dut_vec !== model_vec())
      $display("FAIL prio_setup got U=%0d R=%0d exp U=1 R=2", bus.U, bus.R);
    else passed++;
    press_btn(4'b1100);
    checks++;
    if ({bus.U, bus.L, bus.R} !== 6'd0 || dut_vec !== model_vec())
      $display("FAIL c_priority got U=%0d L=%0d R=%0d exp 0 0 0", bus.U, bus.L, bus.R);
    else passed++;
    press_btn(4'b1000);
    checks++;
    if (dut_vec !== 9'd0 || dut_vec !== model_vec())
      $display("FAIL clear_no_strobe got=%h exp=%h", dut_vec, 9'd0);
    else passed++;
  endtask

  task automatic test_auto_sweep();
    apply_reset(1'b1);
    for (int n = 1; n <= 40; n++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) $display("FAIL auto_model n=%0d got=%h exp=%h", n, dut_vec, model_vec());
      else passed++;
      if (n % 8 == 1 && n > 1) begin
        checks++;
        if (bus.L !== 2'((n / 8) % 4) || bus.mode_changed !== 1'b1 || bus.U !== ((n >= 33) ? 2'd1 : 2'd0))
          $display("FAIL auto_step n=%0d got L=%0d U=%0d mc=%b exp L=%0d U=%0d mc=1", n, bus.L, bus.U, bus.mode_changed, (n / 8) % 4, (n >= 33) ? 1 : 0);
        else passed++;
      end
    end
  endtask

  task automatic test_pause_resume();
    int lf;
    for (int n = 1; n <= 14; n++) begin
      bus.btnC = (n <= 7);
      tick();
      if (n == 7) begin
        checks++;
        if (bus.state !== 2'd2) $display("FAIL pause_enter got=%0d exp=2", bus.state);
        else passed++;
      end
    end
    lf = m_l;
    for (int n = 1; n <= 40; n++) begin
      tick();
      checks++;
      if (bus.L !== 2'(lf) || bus.state !== 2'd2 || dut_vec !== model_vec())
        $display("FAIL pause_freeze n=%0d got L=%0d st=%0d exp L=%0d st=2", n, bus.L, bus.state, lf);
      else passed++;
    end
    for (int n = 1; n <= 20; n++) begin
      bus.btnC = (n <= 7);
      tick();
      checks++;
      if (dut_vec !== model_vec()) $display("FAIL resume_model n=%0d got=%h exp=%h", n, dut_vec, model_vec());
      else passed++;
      if (n == 7 || n == 14 || n == 15) begin
        checks++;
        if (bus.state !== 2'd1 || bus.L !== 2'((n == 15) ? (lf + 1) % 4 : lf))
          $display("FAIL resume_timer n=%0d got L=%0d st=%0d exp L=%0d st=1", n, bus.L, bus.state, (n == 15) ? (lf + 1) % 4 : lf);
        else passed++;
      end
    end
    bus.auto_en = 1'b0;
    tick();
    checks++;
    if (bus.state !== 2'd0) $display("FAIL auto_off got=%0d exp=0", bus.state);
    else passed++;
  endtask

  task automatic test_async_reset();
    apply_reset(1'b1);
    for (int n = 0; n < 20; n++) tick();
    bus.auto_en = 1'b0;
    bus.btnU = 1'b1;
    #2 resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 9'd0) $display("FAIL async_reset got=%h exp=%h", dut_vec, 9'd0);
    else passed++;
    tick();
    tick();
    resetn = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec() || bus.U !== ((n >= 7) ? 2'd1 : 2'd0))
        $display("FAIL reset_requalify n=%0d got U=%0d exp U=%0d", n, bus.U, (n >= 7) ? 1 : 0);
      else passed++;
    end
    bus.btnU = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] b;
    apply_reset(1'b0);
    b = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 5) == 0) b[k] = ~b[k];
      set_btns(b);
      if ($urandom_range(0, 59) == 0) bus.auto_en = ~bus.auto_en;
      if ($urandom_range(0, 399) == 0) begin
        resetn = 1'b0;
        model_reset();
      end else begin
        resetn = 1'b1;
      end
      tick();
      checks++;
      if (dut_vec !== model_vec()) $display("FAIL random n=%0d got=%h exp=%h", n, dut_vec, model_vec());
      else passed++;
    end
    resetn = 1'b1;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    cyc    = 0;
    model_reset();
    test_reset();
    test_manual_step();
    test_glitch();
    test_wrap_priority();
    test_auto_sweep();
    test_pause_resume();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
